// File: rtl/sound_event_trigger.sv
// sound_event_trigger: turns single-cycle game events into a stretched,
// gap-separated PlayAgain request level for the sound player, with the
// code of the event being played on SoundCode.
// Build option: define SOUND_QUEUE_EN for a 4-entry event FIFO; otherwise
// a single pending-event register buffers at most one request.
module sound_event_trigger #(
  parameter int PULSE_CYCLES = 500000,
  parameter int GAP_CYCLES   = 25000000,
  parameter int CNT_WIDTH    = 25
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       HitPaddle,
  input  logic       HitWall,
  input  logic       Scored,
  input  logic       Mute,
  output logic       PlayAgain,
  output logic [1:0] SoundCode,
  output logic       Busy,
  output logic       Dropped
);

  localparam logic [CNT_WIDTH-1:0] PULSE_LOAD = CNT_WIDTH'(PULSE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LOAD   = CNT_WIDTH'(GAP_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO   = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t               state_r;
  logic [CNT_WIDTH-1:0] cnt_r;

  logic       ev_valid_s;
  logic [1:0] ev_code_s;
  logic       ev_multi_s;
  logic       accept_s;
  logic       pop_s;
  logic       q_empty_s;
  logic [1:0] head_code_s;
  logic       q_nxt_nonempty_s;
  logic       drop_s;
  logic       idle_next_s;
  logic       busy_nxt_s;

  // Pick the highest-priority event of this cycle and flag any losers.
  always_comb begin
    ev_valid_s = 1'b1;
    ev_code_s  = 2'd0;
    if (Scored) begin
      ev_code_s = 2'd3;
    end else if (HitPaddle) begin
      ev_code_s = 2'd1;
    end else if (HitWall) begin
      ev_code_s = 2'd2;
    end else begin
      ev_valid_s = 1'b0;
    end
    ev_multi_s = (Scored & (HitPaddle | HitWall)) | (HitPaddle & HitWall);
  end

  assign pop_s = (state_r == IDLE) && !q_empty_s && !Mute;

`ifdef SOUND_QUEUE_EN
  logic [1:0] q_mem_r [4];
  logic [1:0] wr_ptr_r;
  logic [1:0] rd_ptr_r;
  logic [2:0] q_count_r;
  logic [2:0] q_count_nxt_s;

  assign q_empty_s   = (q_count_r == 3'd0);
  assign head_code_s = q_mem_r[rd_ptr_r];
  // A full queue still takes an event when the head leaves in the same cycle.
  assign accept_s    = ev_valid_s && !Mute && ((q_count_r != 3'd4) || pop_s);

  // Next occupancy; mute empties the queue every cycle.
  always_comb begin
    q_count_nxt_s = q_count_r;
    if (Mute) begin
      q_count_nxt_s = 3'd0;
    end else begin
      case ({accept_s, pop_s})
        2'b10:   q_count_nxt_s = q_count_r + 3'd1;
        2'b01:   q_count_nxt_s = q_count_r - 3'd1;
        default: q_count_nxt_s = q_count_r;
      endcase
    end
    q_nxt_nonempty_s = (q_count_nxt_s != 3'd0);
  end

  // FIFO storage and wrapping pointers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 4; i++) q_mem_r[i] <= 2'd0;
      wr_ptr_r  <= 2'd0;
      rd_ptr_r  <= 2'd0;
      q_count_r <= 3'd0;
    end else if (Mute) begin
      wr_ptr_r  <= 2'd0;
      rd_ptr_r  <= 2'd0;
      q_count_r <= 3'd0;
    end else begin
      if (accept_s) begin
        q_mem_r[wr_ptr_r] <= ev_code_s;
        wr_ptr_r          <= wr_ptr_r + 2'd1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 2'd1;
      end
      q_count_r <= q_count_nxt_s;
    end
  end
`else
  logic       pend_valid_r;
  logic [1:0] pend_code_r;

  assign q_empty_s   = !pend_valid_r;
  assign head_code_s = pend_code_r;
  // The single slot accepts only when free or being handed to the FSM.
  assign accept_s    = ev_valid_s && !Mute && (!pend_valid_r || pop_s);

  // Next occupancy of the pending slot.
  always_comb begin
    if (Mute) begin
      q_nxt_nonempty_s = 1'b0;
    end else if (accept_s) begin
      q_nxt_nonempty_s = 1'b1;
    end else if (pop_s) begin
      q_nxt_nonempty_s = 1'b0;
    end else begin
      q_nxt_nonempty_s = pend_valid_r;
    end
  end

  // Single pending-event register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pend_valid_r <= 1'b0;
      pend_code_r  <= 2'd0;
    end else begin
      pend_valid_r <= q_nxt_nonempty_s;
      if (accept_s) begin
        pend_code_r <= ev_code_s;
      end
    end
  end
`endif

  // Muted events vanish silently; otherwise losers and rejects are reported.
  assign drop_s = !Mute && ev_valid_s && (ev_multi_s || !accept_s);

  // Predict whether the block is idle after this edge, for a registered Busy.
  always_comb begin
    idle_next_s = 1'b1;
    case (state_r)
      IDLE:    idle_next_s = !pop_s;
      PULSE:   idle_next_s = 1'b0;
      GAP:     idle_next_s = (cnt_r == CNT_ZERO);
      default: idle_next_s = 1'b1;
    endcase
    busy_nxt_s = !idle_next_s || q_nxt_nonempty_s;
  end

  // Request sequencer: hold PlayAgain for the pulse, then enforce the gap.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      PlayAgain <= 1'b0;
      SoundCode <= 2'd0;
      Busy      <= 1'b0;
      Dropped   <= 1'b0;
    end else begin
      Dropped <= drop_s;
      Busy    <= busy_nxt_s;
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            SoundCode <= head_code_s;
            PlayAgain <= 1'b1;
            cnt_r     <= PULSE_LOAD;
            state_r   <= PULSE;
          end
        end
        PULSE: begin
          if (cnt_r == CNT_ZERO) begin
            PlayAgain <= 1'b0;
            cnt_r     <= GAP_LOAD;
            state_r   <= GAP;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        GAP: begin
          if (cnt_r == CNT_ZERO) begin
            SoundCode <= 2'd0;
            state_r   <= IDLE;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        default: begin
          state_r   <= IDLE;
          cnt_r     <= CNT_ZERO;
          PlayAgain <= 1'b0;
          SoundCode <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sound_event_trigger.sv
// Self-checking bench for sound_event_trigger with short pulse/gap timing.
// Expected play codes are queued as events are driven and matched against
// PlayAgain rises recorded by a monitor.
module tb_sound_event_trigger;

  localparam int PULSE = 4;
  localparam int GAP   = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hp = 1'b0;
  logic       hw = 1'b0;
  logic       sc = 1'b0;
  logic       mute = 1'b0;
  logic       play_again;
  logic [1:0] sound_code;
  logic       busy;
  logic       dropped;

  sound_event_trigger #(.PULSE_CYCLES(PULSE), .GAP_CYCLES(GAP), .CNT_WIDTH(4)) dut (
    .Clock(clk), .Reset(rst_n), .HitPaddle(hp), .HitWall(hw), .Scored(sc),
    .Mute(mute), .PlayAgain(play_again), .SoundCode(sound_code),
    .Busy(busy), .Dropped(dropped)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;

  logic [1:0] exp_q[$];
  logic [1:0] rise_code_q[$];
  int         rise_cyc_q[$];
  int         width_q[$];
  int         bfall_q[$];
  int         drop_cnt = 0;
  int         last_rise = 0;
  logic       pa_prev = 1'b0;
  logic       busy_prev = 1'b0;

  // Monitor: record PlayAgain rises, pulse widths, Busy falls and drops.
  always @(negedge clk) begin
    if (play_again && !pa_prev) begin
      rise_code_q.push_back(sound_code);
      rise_cyc_q.push_back(cyc);
      last_rise = cyc;
    end
    if (!play_again && pa_prev) width_q.push_back(cyc - last_rise);
    if (!busy && busy_prev) bfall_q.push_back(cyc);
    if (dropped) drop_cnt++;
    pa_prev   = play_again;
    busy_prev = busy;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic clear_obs();
    exp_q.delete();
    rise_code_q.delete();
    rise_cyc_q.delete();
    width_q.delete();
    bfall_q.delete();
    drop_cnt = 0;
  endtask

  task automatic drive_event(input logic p, input logic w, input logic s, output int ev);
    hp = p; hw = w; sc = s;
    ev = cyc + 1;
    tick(1);
    hp = 1'b0; hw = 1'b0; sc = 1'b0;
  endtask

  task automatic wait_plays(input int n, input int budget);
    int k = 0;
    while (rise_code_q.size() < n && k < budget) begin
      tick(1);
      k++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    n_checks++; if (play_again !== 1'b0) $display("FAIL reset_play: got %0b expected 0", play_again); else n_pass++;
    n_checks++; if (sound_code !== 2'd0) $display("FAIL reset_code: got %0d expected 0", sound_code); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", busy); else n_pass++;
    n_checks++; if (dropped !== 1'b0) $display("FAIL reset_dropped: got %0b expected 0", dropped); else n_pass++;
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_single_paddle();
    int ev;
    logic [1:0] e;
    clear_obs();
    exp_q.push_back(2'd1);
    drive_event(1'b1, 1'b0, 1'b0, ev);
    wait_plays(1, 40);
    tick(PULSE + GAP + 6);
    n_checks++; if (rise_code_q.size() !== 1) $display("FAIL single_count: got %0d plays expected 1", rise_code_q.size()); else n_pass++;
    if (rise_code_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++; if (rise_code_q[0] !== e) $display("FAIL single_code: got %0d expected %0d", rise_code_q[0], e); else n_pass++;
      n_checks++; if (rise_cyc_q[0] !== ev + 1) $display("FAIL single_latency: rise at %0d expected %0d", rise_cyc_q[0], ev + 1); else n_pass++;
    end
    if (width_q.size() > 0) begin
      n_checks++; if (width_q[0] !== PULSE) $display("FAIL single_width: got %0d expected %0d", width_q[0], PULSE); else n_pass++;
    end else begin
      n_checks++; $display("FAIL single_width: got no falling edge expected width %0d", PULSE);
    end
    if (bfall_q.size() > 0 && rise_cyc_q.size() > 0) begin
      n_checks++;
      if (bfall_q[0] - rise_cyc_q[0] < PULSE + GAP || bfall_q[0] - rise_cyc_q[0] > PULSE + GAP + 1)
        $display("FAIL single_busy: busy fell %0d after rise expected %0d..%0d", bfall_q[0] - rise_cyc_q[0], PULSE + GAP, PULSE + GAP + 1);
      else n_pass++;
    end else begin
      n_checks++; $display("FAIL single_busy: got no busy fall expected one");
    end
    n_checks++; if (drop_cnt !== 0) $display("FAIL single_drops: got %0d expected 0", drop_cnt); else n_pass++;
  endtask

  task automatic test_priority();
    int ev;
    logic [1:0] e;
    clear_obs();
    exp_q.push_back(2'd3);
    drive_event(1'b0, 1'b1, 1'b1, ev);
    wait_plays(1, 40);
    tick(PULSE + GAP + 6);
    n_checks++; if (rise_code_q.size() !== 1) $display("FAIL prio_count: got %0d plays expected 1", rise_code_q.size()); else n_pass++;
    if (rise_code_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++; if (rise_code_q[0] !== e) $display("FAIL prio_code: got %0d expected %0d", rise_code_q[0], e); else n_pass++;
    end
    n_checks++; if (drop_cnt !== 1) $display("FAIL prio_drops: got %0d expected 1", drop_cnt); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int ev;
    int nq;
    int exp_drops;
    logic [1:0] e;
`ifdef SOUND_QUEUE_EN
    nq = 4; exp_drops = 2;
`else
    nq = 1; exp_drops = 5;
`endif
    clear_obs();
    exp_q.push_back(2'd1);
    drive_event(1'b1, 1'b0, 1'b0, ev);
    wait_plays(1, 20);
    for (int i = 0; i < nq; i++) exp_q.push_back(2'd2);
    hw = 1'b1;
    tick(6);
    hw = 1'b0;
    wait_plays(1 + nq, 100);
    tick(PULSE + GAP + 6);
    n_checks++; if (rise_code_q.size() !== 1 + nq) $display("FAIL b2b_count: got %0d plays expected %0d", rise_code_q.size(), 1 + nq); else n_pass++;
    for (int i = 0; i < rise_code_q.size() && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      n_checks++; if (rise_code_q[i] !== e) $display("FAIL b2b_code%0d: got %0d expected %0d", i, rise_code_q[i], e); else n_pass++;
      if (i > 0) begin
        n_checks++;
        if (rise_cyc_q[i] - rise_cyc_q[i-1] !== PULSE + GAP + 1)
          $display("FAIL b2b_spacing%0d: got %0d expected %0d", i, rise_cyc_q[i] - rise_cyc_q[i-1], PULSE + GAP + 1);
        else n_pass++;
      end
      if (i < width_q.size()) begin
        n_checks++; if (width_q[i] !== PULSE) $display("FAIL b2b_width%0d: got %0d expected %0d", i, width_q[i], PULSE); else n_pass++;
      end
    end
    n_checks++; if (drop_cnt !== exp_drops) $display("FAIL b2b_drops: got %0d expected %0d", drop_cnt, exp_drops); else n_pass++;
  endtask

  task automatic test_mute();
    int ev;
    int exp_drops;
    logic [1:0] e;
`ifdef SOUND_QUEUE_EN
    exp_drops = 0;
`else
    exp_drops = 1;
`endif
    clear_obs();
    exp_q.push_back(2'd1);
    drive_event(1'b1, 1'b0, 1'b0, ev);
    wait_plays(1, 20);
    hw = 1'b1; tick(1); hw = 1'b0;
    hp = 1'b1; tick(1); hp = 1'b0;
    mute = 1'b1;
    tick(3);
    hp = 1'b1; tick(1); hp = 1'b0;
    tick(35);
    n_checks++; if (rise_code_q.size() !== 1) $display("FAIL mute_count: got %0d plays expected 1", rise_code_q.size()); else n_pass++;
    if (width_q.size() > 0) begin
      n_checks++; if (width_q[0] !== PULSE) $display("FAIL mute_width: got %0d expected %0d", width_q[0], PULSE); else n_pass++;
    end else begin
      n_checks++; $display("FAIL mute_width: got no falling edge expected width %0d", PULSE);
    end
    if (bfall_q.size() > 0 && rise_cyc_q.size() > 0) begin
      n_checks++;
      if (bfall_q[0] - rise_cyc_q[0] < PULSE + GAP || bfall_q[0] - rise_cyc_q[0] > PULSE + GAP + 1)
        $display("FAIL mute_gap: busy fell %0d after rise expected %0d..%0d", bfall_q[0] - rise_cyc_q[0], PULSE + GAP, PULSE + GAP + 1);
      else n_pass++;
    end else begin
      n_checks++; $display("FAIL mute_gap: got no busy fall expected one");
    end
    n_checks++; if (busy !== 1'b0) $display("FAIL mute_busy: got %0b expected 0", busy); else n_pass++;
    n_checks++; if (drop_cnt !== exp_drops) $display("FAIL mute_drops: got %0d expected %0d", drop_cnt, exp_drops); else n_pass++;
    mute = 1'b0;
    tick(25);
    n_checks++; if (rise_code_q.size() !== 1) $display("FAIL mute_flush: got %0d plays expected 1", rise_code_q.size()); else n_pass++;
    if (rise_code_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++; if (rise_code_q[0] !== e) $display("FAIL mute_code: got %0d expected %0d", rise_code_q[0], e); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_pulse();
    int ev;
    logic [1:0] e;
    clear_obs();
    exp_q.push_back(2'd1);
    drive_event(1'b1, 1'b0, 1'b0, ev);
    wait_plays(1, 20);
    tick(1);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (play_again !== 1'b0) $display("FAIL rstmid_play: got %0b expected 0", play_again); else n_pass++;
    n_checks++; if (sound_code !== 2'd0) $display("FAIL rstmid_code: got %0d expected 0", sound_code); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %0b expected 0", busy); else n_pass++;
    tick(2);
    rst_n = 1'b1;
    tick(30);
    n_checks++; if (rise_code_q.size() !== 1) $display("FAIL rstmid_resume: got %0d plays expected 1", rise_code_q.size()); else n_pass++;
    if (rise_code_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++; if (rise_code_q[0] !== e) $display("FAIL rstmid_code0: got %0d expected %0d", rise_code_q[0], e); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single_paddle();
    test_priority();
    test_back_to_back();
    test_mute();
    test_reset_mid_pulse();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
